// File: rtl/wt_product_accumulator.sv
// ============================================================================
// wt_product_accumulator
// ----------------------------------------------------------------------------
// Sums a burst of unsigned products coming from the 4x4 Wallace-tree
// multiplier. The burst length is captured when start is accepted. Products
// arrive over a valid/ready handshake. The sum is then offered once on an
// output valid/ready handshake. The block is used for dot-product and
// error-statistics runs over the approximate multiplier.
//
// Optional feature macro: ACC_SAT_EN
//   defined   : on a carry out of ACC_W bits, acc_out saturates to all-ones
//               and stays there for the rest of the burst (ovf is still set).
//   undefined : acc_out wraps modulo 2^ACC_W (default build).
//
// Parameters
//   PROD_W  width of an incoming product (multiplier output O)
//   ACC_W   accumulator / result width, must be >= PROD_W
//   LEN_W   width of the burst-length field (max burst = 2^LEN_W-1)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a burst (only looked at in IDLE)
//   len         in   number of products in the burst, captured with start
//   prod_valid  in   upstream product valid
//   prod_ready  out  block accepts a product this cycle (ACC state)
//   prod        in   unsigned product value
//   acc_valid   out  result valid (DONE state)
//   acc_ready   in   downstream accepts the result
//   acc_out     out  accumulated sum, held in IDLE until the next start
//   busy        out  high in every state except IDLE
//   ovf         out  sticky carry-out flag for the current/last burst
// ============================================================================
module wt_product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   acc_next;
    logic [LEN_W-1:0]   cnt_reg;
    logic [LEN_W-1:0]   len_q_reg;
    logic               ovf_reg;

    logic               xfer;
    logic               last_xfer;
    logic               start_accept;
    logic [ACC_W:0]     sum;
    logic               carry;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign start_accept = (state_reg == IDLE) && start;
    assign xfer         = (state_reg == ACC) && prod_valid;
    // Last product of the burst: the counter still holds the number of
    // products taken so far, so the final one arrives at cnt == len_q-1.
    assign last_xfer    = xfer && (cnt_reg == (len_q_reg - LEN_W'(1)));

    // ------------------------------------------------------------------
    // Adder: one spare bit on top catches the carry out of ACC_W.
    // ------------------------------------------------------------------
    assign sum   = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry = sum[ACC_W];

`ifdef ACC_SAT_EN
    // ovf_reg is cleared on start, so it marks an earlier carry in this
    // burst. Once the sum has saturated it is pinned at all-ones.
    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (carry || ovf_reg) begin
            acc_next = '1;
        end
    end
`else
    // Wrap-around: simply drop the carry bit.
    always_comb begin
        acc_next = sum[ACC_W-1:0];
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    // A zero-length burst goes straight to presenting 0.
                    state_next = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (last_xfer) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (acc_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (purely from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
            end
            ACC: begin
                prod_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                acc_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: accumulator, product counter, latched length
    // and the sticky overflow flag. All of them hold unless a burst is
    // being started or a product is transferred. This keeps the result
    // stable in DONE and retained in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            len_q_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (start_accept) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            len_q_reg <= len;
            ovf_reg   <= 1'b0;
        end else if (xfer) begin
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_reg + LEN_W'(1);
            ovf_reg   <= ovf_reg | carry;
        end
    end

    assign acc_out = acc_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_wt_product_accumulator.sv
// ============================================================================
// tb_wt_product_accumulator
// ----------------------------------------------------------------------------
// Two instances of the accumulator share every input: one uses ACC_W=16 and
// the other uses ACC_W=8, so each burst also exercises the narrow wrap and
// saturate path. Expected sums come from plain integer arithmetic over the
// queue of products sent so far.
// ============================================================================
module tb_wt_product_accumulator;

    localparam int PROD_W = 8;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              acc_ready;

    logic              prod_ready16, acc_valid16, busy16, ovf16;
    logic [15:0]       acc_out16;
    logic              prod_ready8, acc_valid8, busy8, ovf8;
    logic [7:0]        acc_out8;

    int checks = 0;
    int errors = 0;
    int q[$];

    always #5 clk = ~clk;

    wt_product_accumulator #(.PROD_W(PROD_W), .ACC_W(16), .LEN_W(LEN_W)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready16), .prod(prod),
        .acc_valid(acc_valid16), .acc_ready(acc_ready), .acc_out(acc_out16),
        .busy(busy16), .ovf(ovf16)
    );

    wt_product_accumulator #(.PROD_W(PROD_W), .ACC_W(8), .LEN_W(LEN_W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready8), .prod(prod),
        .acc_valid(acc_valid8), .acc_ready(acc_ready), .acc_out(acc_out8),
        .busy(busy8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: true sum of the first k products, reduced to a w-bit result.
    function automatic longint true_sum(input int k);
        longint t = 0;
        for (int i = 0; i < k; i++) t += q[i];
        return t;
    endfunction

    function automatic logic [31:0] exp_acc(input int w, input int k);
        longint t   = true_sum(k);
        longint lim = longint'(1) << w;
        if (t < lim) return 32'(t);
`ifdef ACC_SAT_EN
        return 32'(lim - 1);
`else
        return 32'(t % lim);
`endif
    endfunction

    // Any carry happened iff the true running total reached 2^w.
    function automatic logic [31:0] exp_ovf(input int w, input int k);
        return (true_sum(k) >= (longint'(1) << w)) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk_flags(input string tag, input logic pr, input logic av, input logic bz);
        chk({tag, ".prod_ready16"}, 32'(prod_ready16), 32'(pr));
        chk({tag, ".acc_valid16"},  32'(acc_valid16),  32'(av));
        chk({tag, ".busy16"},       32'(busy16),       32'(bz));
        chk({tag, ".prod_ready8"},  32'(prod_ready8),  32'(pr));
        chk({tag, ".acc_valid8"},   32'(acc_valid8),   32'(av));
        chk({tag, ".busy8"},        32'(busy8),        32'(bz));
    endtask

    task automatic chk_sum(input string tag, input int k);
        chk({tag, ".acc16"}, 32'(acc_out16), exp_acc(16, k));
        chk({tag, ".ovf16"}, 32'(ovf16),     exp_ovf(16, k));
        chk({tag, ".acc8"},  32'(acc_out8),  exp_acc(8, k));
        chk({tag, ".ovf8"},  32'(ovf8),      exp_ovf(8, k));
    endtask

    // Runs one burst of n products taken from q. The task is entered and
    // left at a falling edge. Gaps of gmin..gmax idle cycles are inserted
    // before each product. The result is back-pressured for bp cycles.
    // Stray start pulses during ACC/DONE must be ignored.
    task automatic run_burst(input string tag, input int n, input int gmin,
                             input int gmax, input int bp);
        int g;
        chk_flags({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        len   = LEN_W'($urandom);
        for (int i = 0; i < n; i++) begin
            g = int'($urandom_range(gmax, gmin));
            for (int j = 0; j < g; j++) begin
                prod_valid = 1'b0;
                prod       = PROD_W'($urandom);
                start      = 1'($urandom);
                chk_flags({tag, ".gap"}, 1'b1, 1'b0, 1'b1);
                chk_sum({tag, ".gap"}, i);
                @(negedge clk);
            end
            prod_valid = 1'b1;
            prod       = PROD_W'(q[i]);
            start      = 1'($urandom);
            chk_flags({tag, ".acc"}, 1'b1, 1'b0, 1'b1);
            chk_sum({tag, ".acc"}, i);
            @(negedge clk);
        end
        prod_valid = 1'b0;
        start      = 1'b0;
        for (int b = 0; b < bp; b++) begin
            acc_ready = 1'b0;
            start     = (b % 2 == 0);
            chk_flags({tag, ".hold"}, 1'b0, 1'b1, 1'b1);
            chk_sum({tag, ".hold"}, n);
            @(negedge clk);
        end
        acc_ready = 1'b1;
        start     = 1'b1;  // coincides with the hand-off: must be ignored
        chk_flags({tag, ".done"}, 1'b0, 1'b1, 1'b1);
        chk_sum({tag, ".done"}, n);
        @(negedge clk);
        acc_ready = 1'b0;
        start     = 1'b0;
        chk_flags({tag, ".after"}, 1'b0, 1'b0, 1'b0);
        chk_sum({tag, ".after"}, n);
        $display("burst %s len=%0d sum=%0d acc16=%0d acc8=%0d ovf8=%0d",
                 tag, n, true_sum(n), acc_out16, acc_out8, ovf8);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        prod_valid = 1'b0;
        prod       = '0;
        acc_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.acc16", 32'(acc_out16), 32'd0);
        chk("reset.ovf16", 32'(ovf16), 32'd0);
        chk("reset.acc8",  32'(acc_out8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic back-to-back burst: 225+10+20 = 255.
        q = '{225, 10, 20};
        run_burst("basic", 3, 0, 0, 0);
        chk("basic.const", 32'(acc_out16), 32'd255);

        // Upstream gaps of two cycles between products.
        q = '{1, 2, 3, 4};
        run_burst("gaps", 4, 2, 2, 0);
        chk("gaps.const", 32'(acc_out16), 32'd10);

        // Zero-length burst goes straight to DONE with 0.
        q = {};
        run_burst("len0", 0, 0, 0, 1);

        // Maximum burst of 255*255 = 65025, then a narrow-width overflow.
        q = {};
        for (int i = 0; i < 255; i++) q.push_back(255);
        run_burst("max", 255, 0, 0, 0);
        chk("max.const", 32'(acc_out16), 32'd65025);
        q = '{200, 100};
        run_burst("ovf", 2, 0, 0, 0);
`ifdef ACC_SAT_EN
        chk("ovf.const8", 32'(acc_out8), 32'd255);
`else
        chk("ovf.const8", 32'(acc_out8), 32'd44);
`endif
        chk("ovf.flag8", 32'(ovf8), 32'd1);

        // Back-pressure for 10 cycles with start pulses in DONE.
        q = '{50, 60, 70};
        run_burst("bp", 3, 0, 1, 10);

        // Randomised bursts.
        for (int r = 0; r < 20; r++) begin
            n = int'($urandom_range(12, 0));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(255, 0)));
            run_burst($sformatf("rnd%0d", r), n, 0, 2, int'($urandom_range(3, 0)));
        end

        // Reset in the middle of a burst of 5, after 2 products.
        q = '{11, 22, 33, 44, 55};
        start = 1'b1;
        len   = LEN_W'(5);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            prod       = PROD_W'(q[i]);
            @(negedge clk);
        end
        chk_sum("mid", 2);
        prod = PROD_W'(q[2]);
        #2 rst_n = 1'b0;
        #1;
        chk_flags("rst_async", 1'b0, 1'b0, 1'b0);
        chk("rst_async.acc16", 32'(acc_out16), 32'd0);
        chk("rst_async.ovf16", 32'(ovf16), 32'd0);
        chk("rst_async.acc8",  32'(acc_out8), 32'd0);
        chk("rst_async.ovf8",  32'(ovf8), 32'd0);
        $display("reset asserted mid-burst acc16=%0d busy16=%0d", acc_out16, busy16);
        @(negedge clk);
        prod_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        q = '{7};
        run_burst("post_rst", 1, 0, 0, 0);
        chk("post_rst.const", 32'(acc_out16), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
